// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC refresh path: FSM encoding, memory slot map and
// the chip-register sweep table.
package rtc_pkg;

  typedef enum logic [2:0] {StIdle, StReq, StWait, StConv, StWrite, StNext} state_e;

  localparam int unsigned SWEEP_LEN = 9;

  localparam logic [3:0] SEG     = 4'd1;
  localparam logic [3:0] MIN     = 4'd2;
  localparam logic [3:0] HOR     = 4'd3;
  localparam logic [3:0] DIA     = 4'd4;
  localparam logic [3:0] MES     = 4'd5;
  localparam logic [3:0] ANO     = 4'd6;
  localparam logic [3:0] TMR_SEG = 4'd9;
  localparam logic [3:0] TMR_MIN = 4'd10;
  localparam logic [3:0] TMR_HOR = 4'd11;
  localparam logic [3:0] PTR     = 4'd12;

  function automatic logic [3:0] sweep_slot(input logic [3:0] idx);
    case (idx)
      4'd0:    sweep_slot = SEG;
      4'd1:    sweep_slot = MIN;
      4'd2:    sweep_slot = HOR;
      4'd3:    sweep_slot = DIA;
      4'd4:    sweep_slot = MES;
      4'd5:    sweep_slot = ANO;
      4'd6:    sweep_slot = TMR_SEG;
      4'd7:    sweep_slot = TMR_MIN;
      4'd8:    sweep_slot = TMR_HOR;
      default: sweep_slot = 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] sweep_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    sweep_addr = 8'h21;
      4'd1:    sweep_addr = 8'h22;
      4'd2:    sweep_addr = 8'h23;
      4'd3:    sweep_addr = 8'h24;
      4'd4:    sweep_addr = 8'h25;
      4'd5:    sweep_addr = 8'h26;
      4'd6:    sweep_addr = 8'h41;
      4'd7:    sweep_addr = 8'h42;
      4'd8:    sweep_addr = 8'h43;
      default: sweep_addr = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] sweep_mask(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1, 4'd6, 4'd7: sweep_mask = 8'h7F;
      4'd2, 4'd3, 4'd8:       sweep_mask = 8'h3F;
      4'd4:                   sweep_mask = 8'h1F;
      4'd5:                   sweep_mask = 8'hFF;
      default:                sweep_mask = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/bcd2bin.sv
// Combinational packed-BCD byte to binary converter; valid_o is low when either
// nibble exceeds 9.
module bcd2bin (
  input  logic [7:0] bcd_i,
  output logic [7:0] bin_o,
  output logic       valid_o
);

  logic [7:0] hi;
  logic [7:0] lo;

  assign hi      = {4'b0, bcd_i[7:4]};
  assign lo      = {4'b0, bcd_i[3:0]};
  // hi*10 as hi*8 + hi*2
  assign bin_o   = (hi << 3) + (hi << 1) + lo;
  assign valid_o = (bcd_i[7:4] <= 4'd9) && (bcd_i[3:0] <= 4'd9);

endmodule

// File: rtl/rtc_refresh_sequencer.sv
// Periodically reads the RTC chip time/timer registers, converts BCD to binary and
// writes the results into the RTC register memory slots.
module rtc_refresh_sequencer
  import rtc_pkg::*;
#(
  parameter int unsigned REFRESH_TICKS = 1000000,
  parameter int unsigned TIMEOUT_CYC   = 255
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       pause_i,
  input  logic       force_sweep_i,
  output logic       bus_req_o,
  output logic [7:0] bus_addr_o,
  input  logic [7:0] bus_rdata_i,
  input  logic       bus_done_i,
  output logic [3:0] mem_add_o,
  output logic [7:0] mem_dat_o,
  output logic       mem_w_o,
  output logic       sweep_busy_o,
  output logic       bcd_err_o
);

  localparam int unsigned TickW = $clog2(REFRESH_TICKS + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TickW-1:0] TickLast = TickW'(REFRESH_TICKS - 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       IdxLast  = 4'(SWEEP_LEN - 1);

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic [TickW-1:0]  tick_q, tick_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              force_pend_q, force_pend_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        bus_addr_q, bus_addr_d;
  logic [3:0]        mem_add_q, mem_add_d;
  logic [7:0]        mem_dat_q, mem_dat_d;
  logic              mem_w_q, mem_w_d;
  logic              bcd_err_q, bcd_err_d;
  logic [7:0]        conv_bin;
  logic              conv_valid;

  bcd2bin u_bcd2bin (
    .bcd_i   (data_q),
    .bin_o   (conv_bin),
    .valid_o (conv_valid)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tick_d       = tick_q;
    tmo_d        = tmo_q;
    force_pend_d = force_pend_q | force_sweep_i;
    data_d       = data_q;
    bus_addr_d   = bus_addr_q;
    mem_add_d    = mem_add_q;
    mem_dat_d    = mem_dat_q;
    mem_w_d      = 1'b0;
    bcd_err_d    = bcd_err_q;
    unique case (state_q)
      StIdle: begin
        if (!pause_i && (tick_q == TickLast || force_pend_q || force_sweep_i)) begin
          // Sweeps always start at index 0, so the error flag clears on REQ entry.
          tick_d       = '0;
          force_pend_d = 1'b0;
          bcd_err_d    = 1'b0;
          bus_addr_d   = sweep_addr(idx_q);
          state_d      = StReq;
        end else if (tick_q != TickLast) begin
          tick_d = tick_q + TickW'(1);
        end
      end
      StReq: begin
        tmo_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        tmo_d = tmo_q + TmoW'(1);
        if (bus_done_i) begin
          data_d  = bus_rdata_i & sweep_mask(idx_q);
          state_d = StConv;
        end else if (tmo_q == TmoLast) begin
          bcd_err_d = 1'b1;
          idx_d     = '0;
          state_d   = StIdle;
        end
      end
      StConv: begin
        if (conv_valid) begin
          mem_w_d   = 1'b1;
          mem_add_d = sweep_slot(idx_q);
          mem_dat_d = conv_bin;
        end else begin
          bcd_err_d = 1'b1;
        end
        state_d = StWrite;
      end
      StWrite: state_d = StNext;
      StNext: begin
        if (idx_q == IdxLast) begin
          idx_d   = '0;
          state_d = StIdle;
        end else begin
          idx_d      = idx_q + 4'd1;
          bus_addr_d = sweep_addr(idx_q + 4'd1);
          state_d    = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      tick_q       <= '0;
      tmo_q        <= '0;
      force_pend_q <= 1'b0;
      data_q       <= '0;
      bus_addr_q   <= '0;
      mem_add_q    <= '0;
      mem_dat_q    <= '0;
      mem_w_q      <= 1'b0;
      bcd_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tick_q       <= tick_d;
      tmo_q        <= tmo_d;
      force_pend_q <= force_pend_d;
      data_q       <= data_d;
      bus_addr_q   <= bus_addr_d;
      mem_add_q    <= mem_add_d;
      mem_dat_q    <= mem_dat_d;
      mem_w_q      <= mem_w_d;
      bcd_err_q    <= bcd_err_d;
    end
  end

  assign bus_req_o    = (state_q == StReq) || (state_q == StWait);
  assign bus_addr_o   = bus_addr_q;
  assign mem_add_o    = mem_add_q;
  assign mem_dat_o    = mem_dat_q;
  assign mem_w_o      = mem_w_q;
  assign sweep_busy_o = (state_q != StIdle);
  assign bcd_err_o    = bcd_err_q;

endmodule

// File: tb/tb_rtc_refresh_sequencer.sv
// Bench for rtc_refresh_sequencer: directed scenarios plus random traffic, checked
// every cycle against an entry-timeline model of the sweep.
module tb_rtc_refresh_sequencer;

  localparam int RT = 8;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst, pause, force_sw, bus_done;
  logic [7:0] bus_rdata;
  logic       bus_req, mem_w, sweep_busy, bcd_err;
  logic [7:0] bus_addr, mem_dat;
  logic [3:0] mem_add;

  rtc_refresh_sequencer #(.REFRESH_TICKS(RT), .TIMEOUT_CYC(TO)) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .pause_i      (pause),
    .force_sweep_i(force_sw),
    .bus_req_o    (bus_req),
    .bus_addr_o   (bus_addr),
    .bus_rdata_i  (bus_rdata),
    .bus_done_i   (bus_done),
    .mem_add_o    (mem_add),
    .mem_dat_o    (mem_dat),
    .mem_w_o      (mem_w),
    .sweep_busy_o (sweep_busy),
    .bcd_err_o    (bcd_err)
  );

  initial forever #5 clk = ~clk;

  int ADDR_T [9] = '{'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h41, 'h42, 'h43};
  int MASK_T [9] = '{'h7F, 'h7F, 'h3F, 'h3F, 'h1F, 'hFF, 'h7F, 'h7F, 'h3F};
  int SLOT_T [9] = '{1, 2, 3, 4, 5, 6, 9, 10, 11};

  int total = 0, bad = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- bus responder ----------------
  logic [7:0] rd_val [256];
  bit         withhold [256];
  int         lat = 2;
  bit         spurious_en = 0;

  initial begin
    int cnt;
    bit served;
    cnt = 0; served = 0; bus_done = 0; bus_rdata = 0;
    forever begin
      @(posedge clk); #1;
      bus_done  = 0;
      bus_rdata = 8'($urandom);
      if (bus_req && !served) begin
        cnt++;
        if (!withhold[bus_addr] && cnt >= lat + 1) begin
          bus_done = 1; bus_rdata = rd_val[bus_addr]; served = 1;
        end
      end else if (!bus_req) begin
        served = 0; cnt = 0;
        if (spurious_en && $urandom_range(0, 9) == 0) bus_done = 1;
      end
    end
  end

  // ---------------- reference model ----------------
  // A sweep is a list of entries; each entry is a timeline measured from its request
  // cycle (t=0), with wait cycles t>=1 and conv/write/next at done+1..done+3.
  int m_tick, m_pend, m_act, m_idx, m_t, m_done_at, m_err, m_w, m_add, m_dat, m_val;

  task automatic model_step();
    int hi, lo, pend_n;
    if (rst) begin
      m_tick = 0; m_pend = 0; m_act = 0; m_idx = 0; m_t = 0; m_done_at = -1;
      m_err = 0; m_w = 0; m_add = 0; m_dat = 0;
      return;
    end
    pend_n = m_pend | int'(force_sw);
    m_w = 0;
    if (m_act == 0) begin
      if (!pause && (m_tick == RT - 1 || m_pend != 0 || force_sw)) begin
        m_act = 1; m_idx = 0; m_t = 0; m_done_at = -1; m_tick = 0; pend_n = 0; m_err = 0;
      end else if (m_tick != RT - 1) m_tick++;
    end else if (m_done_at < 0) begin
      if (m_t >= 1 && bus_done) begin
        m_done_at = m_t; m_val = int'(bus_rdata) & MASK_T[m_idx]; m_t++;
      end else if (m_t == TO) begin
        m_err = 1; m_act = 0; m_idx = 0;
      end else m_t++;
    end else begin
      if (m_t == m_done_at + 1) begin
        hi = m_val / 16; lo = m_val % 16;
        if (hi <= 9 && lo <= 9) begin
          m_w = 1; m_add = SLOT_T[m_idx]; m_dat = (hi * 10 + lo) % 256;
        end else m_err = 1;
      end
      if (m_t == m_done_at + 3) begin
        if (m_idx == 8) begin m_act = 0; m_idx = 0; end
        else begin m_idx++; m_t = 0; m_done_at = -1; end
      end else m_t++;
    end
    m_pend = pend_n;
  endtask

  initial begin
    m_done_at = -1;
    forever begin @(posedge clk); model_step(); end
  end

  // ---------------- compare + write log ----------------
  int wr_count;
  bit wr_seen [16];
  int mem_img [16];
  int addr_log [$];
  int run = 0, last_run = 0;
  bit prev_req = 0;

  task automatic clear_log();
    wr_count = 0;
    for (int i = 0; i < 16; i++) begin wr_seen[i] = 0; mem_img[i] = -1; end
    addr_log.delete();
  endtask

  initial forever begin
    bit m_req;
    @(negedge clk);
    if (chk_en) begin
      m_req = (m_act != 0) && (m_done_at < 0);
      chk("sweep_busy", sweep_busy, m_act);
      chk("bus_req", bus_req, m_req);
      if (m_req) chk("bus_addr", bus_addr, ADDR_T[m_idx]);
      chk("mem_w", mem_w, m_w);
      chk("mem_add", mem_add, m_add);
      chk("mem_dat", mem_dat, m_dat);
      chk("bcd_err", bcd_err, m_err);
      if (mem_w) begin wr_count++; wr_seen[mem_add] = 1; mem_img[mem_add] = int'(mem_dat); end
      if (bus_req && !prev_req) addr_log.push_back(int'(bus_addr));
      if (bus_req) run++;
      else begin if (prev_req) last_run = run; run = 0; end
      prev_req = bus_req;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (sweep_busy && n < bound) begin @(negedge clk); n++; end
    if (sweep_busy) chk("wait_idle_bound", 1, 0);
  endtask

  task automatic pulse_force();
    force_sw = 1; cyc(); force_sw = 0;
  endtask

  initial begin
    int n, k;
    rst = 1; pause = 0; force_sw = 0;
    for (int a = 0; a < 256; a++) begin rd_val[a] = 8'h00; withhold[a] = 0; end
    rd_val['h21] = 8'h59; rd_val['h22] = 8'h34; rd_val['h23] = 8'hE3;
    rd_val['h24] = 8'h15; rd_val['h25] = 8'h12; rd_val['h26] = 8'h99;
    rd_val['h41] = 8'h30; rd_val['h42] = 8'h45; rd_val['h43] = 8'h07;
    clear_log();
    @(posedge clk); chk_en = 1;
    cyc(); cyc();
    rst = 0;

    // Sweep order, conversion and masking
    n = 0;
    while (n < 50) begin @(negedge clk); if (bus_req) break; n++; end
    chk("first_req_cycle", n, 8);
    wait_idle(300); cyc();
    chk("sweep_write_count", wr_count, 9);
    chk("slot1_sec", mem_img[1], 59);
    chk("slot3_hour_masked", mem_img[3], 23);
    chk("slot6_year", mem_img[6], 99);
    chk("slot11_tmr_hour", mem_img[11], 7);
    for (int i = 0; i < 9; i++)
      chk("addr_order", (i < addr_log.size()) ? addr_log[i] : 'hFFF, ADDR_T[i]);

    // Invalid BCD skips the write and latches the error
    rd_val['h22] = 8'h7A; clear_log(); pulse_force();
    wait_idle(300); cyc();
    chk("bad_bcd_no_slot2", wr_seen[2], 0);
    chk("bad_bcd_write_count", wr_count, 8);
    chk("bad_bcd_err", bcd_err, 1);
    rd_val['h22] = 8'h34; force_sw = 1;
    @(negedge clk); chk("err_held_idle", bcd_err, 1);
    cyc(); force_sw = 0;
    @(negedge clk); chk("req_after_force", bus_req, 1); chk("err_cleared_req", bcd_err, 0);
    wait_idle(300);

    // Timeout on the third entry
    cyc(); withhold['h23] = 1; clear_log(); pulse_force();
    wait_idle(300); cyc();
    chk("tmo_write_count", wr_count, 2);
    chk("tmo_slot1", wr_seen[1], 1);
    chk("tmo_slot2", wr_seen[2], 1);
    chk("tmo_err", bcd_err, 1);
    chk("tmo_req_len", last_run, 1 + TO);
    withhold['h23] = 0;

    // Pause over terminal count, force while paused, then force mid-sweep
    pause = 1; n = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (bus_req) n++; end
    chk("paused_no_req", n, 0);
    cyc(); pulse_force();
    pause = 0;
    @(negedge clk); chk("req_low_at_unpause", bus_req, 0);
    @(negedge clk); chk("req_after_unpause", bus_req, 1);
    repeat (10) @(negedge clk);
    cyc(); pulse_force();
    wait_idle(300);
    n = 1;
    while (n < 20) begin @(negedge clk); if (sweep_busy) break; n++; end
    chk("force_idle_gap", n, 1);
    wait_idle(300);

    // Reset in the middle of a wait
    cyc(); withhold['h21] = 1; pulse_force();
    @(negedge clk); @(negedge clk);
    cyc(); rst = 1; withhold['h21] = 0; clear_log();
    cyc(); rst = 0;
    @(negedge clk);
    chk("rst_bus_req", bus_req, 0); chk("rst_bus_addr", bus_addr, 0);
    chk("rst_busy", sweep_busy, 0); chk("rst_mem_w", mem_w, 0);
    chk("rst_mem_add", mem_add, 0); chk("rst_mem_dat", mem_dat, 0);
    chk("rst_err", bcd_err, 0);
    n = 1;
    while (n < 50) begin @(negedge clk); if (bus_req) break; n++; end
    chk("req_after_reset", n, 8);
    chk("addr_after_reset", bus_addr, 'h21);
    wait_idle(300); cyc();
    chk("post_reset_writes", wr_count, 9);

    // Random traffic
    spurious_en = 1;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      force_sw = ($urandom_range(0, 30) == 0);
      rst = ($urandom_range(0, 400) == 0);
      lat = $urandom_range(1, 3);
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, 8);
        if ($urandom_range(0, 1) == 0)
          rd_val[ADDR_T[k]] = 8'(($urandom_range(0, 9) << 4) | $urandom_range(0, 9));
        else
          rd_val[ADDR_T[k]] = 8'($urandom);
        withhold[ADDR_T[k]] = ($urandom_range(0, 12) == 0);
      end
    end
    cyc(); rst = 0; force_sw = 0; pause = 0;
    for (int a = 0; a < 256; a++) withhold[a] = 0;
    wait_idle(300);
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rtc_refresh_sequencer.md
Name: rtc_refresh_sequencer

Overview:
- Upstream feeder of the RTC register memory.
- Periodically sweeps the external RTC chip's time and timer registers over a request/done bus-read handshake.
- Converts each BCD byte to binary and writes it into the memory's write port (add/dat/w) at the fixed slot map.
- Keeps the memory's binary seconds/minutes/hours/date/timer copy coherent with the chip, and pauses while the host is editing.

Parameters:
- REFRESH_TICKS, 1000000, clk cycles between sweep starts (10 ms at 100 MHz).
- TIMEOUT_CYC, 255, max cycles to wait for bus_done before aborting the sweep.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pause  in  1  host edit in progress; blocks new sweeps
- force_sweep  in  1  one-cycle pulse; start a sweep at the next IDLE cycle
- bus_req  out  1  read request to RTC bus interface; held until bus_done
- bus_addr  out  8  RTC chip register address
- bus_rdata  in  8  read data; valid in the bus_done cycle
- bus_done  in  1  one-cycle completion pulse
- mem_add  out  4  memory slot address
- mem_dat  out  8  binary value to write
- mem_w  out  1  one-cycle write strobe
- sweep_busy  out  1  high from REQ entry until return to IDLE
- bcd_err  out  1  sticky; set on invalid BCD or timeout, cleared at next sweep start

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset, and has priority in every state.
- Reset values:
  - All outputs 0.
  - FSM = IDLE, entry index = 0, tick counter = 0, timeout counter = 0.
- Sweep table (9 entries, in order), as slot<-chip address/mask:
  - 1<-0x21/0x7F, 2<-0x22/0x7F, 3<-0x23/0x3F, 4<-0x24/0x3F, 5<-0x25/0x1F, 6<-0x26/0xFF
  - 9<-0x41/0x7F, 10<-0x42/0x7F, 11<-0x43/0x3F
- IDLE:
  - Tick counter increments each cycle.
  - At REFRESH_TICKS-1 with pause=0: counter reloads to 0, go to REQ.
  - At REFRESH_TICKS-1 with pause=1: counter holds at REFRESH_TICKS-1.
  - A force_sweep pulse seen while pause=0 also goes to REQ and reloads the counter. force_sweep is latched into a pending flag and is never lost, even when it arrives during a sweep or while pause=1.
- REQ: bcd_err clears here, but only when index=0. Drive bus_req=1 and bus_addr=table[idx], then go to WAIT.
- WAIT:
  - bus_req stays 1 and the timeout counter increments.
  - On bus_done: latch bus_rdata AND mask, drop bus_req the next cycle, go to CONV.
  - If the timeout counter reaches TIMEOUT_CYC with no bus_done: bus_req=0, bcd_err=1, index=0, go to IDLE (sweep aborted; remaining slots are not written).
- CONV:
  - bin = hi*10 + lo, computed in 8-bit.
  - If hi>9 or lo>9: bcd_err=1 and this entry's write is skipped.
- WRITE:
  - mem_add, mem_dat and mem_w=1 for exactly one cycle.
  - mem_add/mem_dat hold their values afterwards; mem_w returns to 0.
- NEXT: index++. If index was 8, index=0 and go to IDLE; otherwise go to REQ.
- Latency per entry: 1 REQ cycle + bus latency + CONV + WRITE + NEXT. The first bus_req rises 1 cycle after the trigger.
- pause is sampled only in IDLE; a sweep already in progress always completes.
- A bus_done arriving outside WAIT is ignored.
- Reset mid-sweep aborts with no further mem_w.

Decomposition:
- Shared package rtc_pkg holds:
  - the FSM state encoding;
  - SWEEP_LEN=9;
  - the slot/chip-address/mask constant tables;
  - memory slot index constants (SEG=1 … TMR_HOR=11, PTR=12).
- One natural sub-module: bcd2bin, a combinational 8-bit BCD-to-binary converter with a valid flag, reused by later display-side blocks.

Test Plan (REFRESH_TICKS=8, TIMEOUT_CYC=4):
- Sweep order and conversion: after reset, with no pause, a bus model returns 0x59 for 0x21 with 2-cycle latency.
  - First bus_req occurs at cycle 8, with addresses 0x21..0x26, 0x41..0x43 in order.
  - mem_w writes slot 1 = 59; exactly 9 mem_w pulses; sweep_busy falls after the last NEXT.
- Mask: hours returns 0xE3 -> slot 3 written with 23; year returns 0x99 -> slot 6 = 99.
- Bad BCD: minutes returns 0x7A -> no mem_w to slot 2, bcd_err=1. bcd_err stays 1 until the next sweep's REQ at index 0, then clears.
- Timeout: bus_done withheld on the 3rd entry -> bus_req drops after 4 WAIT cycles, bcd_err=1, FSM back in IDLE, only slots 1 and 2 written.
- Pause and force: pause=1 over the terminal count -> no bus_req while paused.
  - Drop pause -> bus_req next cycle.
  - force_sweep mid-sweep -> a second sweep starts immediately after the first returns to IDLE.
- Reset mid-WAIT: all outputs 0 on the next cycle, no mem_w, and the next sweep starts at index 0 after 8 cycles.
